// File: rtl/cpu_mem_arb_if.sv
// Bus bundle between requesters and the shared-memory arbiter.
// Per-port fields are packed; port p occupies slice [p*W +: W].
interface cpu_mem_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NPORTS = 2
);
  logic [NPORTS-1:0]        req;
  logic [NPORTS-1:0]        we;
  logic [NPORTS*ADDR_W-1:0] addr;
  logic [NPORTS*DATA_W-1:0] wdata;
  logic [NPORTS-1:0]        gnt;
  logic [NPORTS-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cpu_mem_arb.sv
// Round-robin arbiter in front of a single-port memory, with a LATENCY-deep read
// pipeline that tags each returning word with the port that issued the read.
module cpu_mem_arb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int NPORTS  = 2,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_mem_arb_if.slave bus
);
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [NPORTS-1:0] gnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_acc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NPORTS-1:0] vld_q [LATENCY];
  logic [NPORTS-1:0] vld_d [LATENCY];
  logic [DATA_W-1:0] dat_q [LATENCY];
  logic [DATA_W-1:0] dat_d [LATENCY];

  // Search starts at the pointer and wraps; reset suppresses every grant.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NPORTS);
      if (rst_n && !gnt_any && bus.req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (gnt[p]) begin
        sel_we    = bus.we[p];
        sel_addr  = bus.addr[p*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[p*DATA_W +: DATA_W];
      end
    end
    rd_acc = gnt_any && !sel_we;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Each stage keeps its data when a bubble passes, so the last stage
  // doubles as the hold register for rdata between strobes.
  always_comb begin
    vld_d[0] = rd_acc ? gnt : '0;
    dat_d[0] = rd_acc ? mem[sel_addr] : dat_q[0];
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = (|vld_q[k-1]) ? dat_q[k-1] : dat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= '0;
        dat_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= vld_d[k];
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (gnt_any && sel_we) mem[sel_addr] <= sel_wdata;
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = vld_q[LATENCY-1];
  assign bus.rdata  = dat_q[LATENCY-1];
endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed and randomized bench for cpu_mem_arb (2 ports, LATENCY=2) checked
// every cycle against a queue-based behavioural model of the arbiter and memory.
module tb_cpu_mem_arb;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int NPORTS  = 2;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
    bit                known;
  } rd_t;

  logic clk;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  cpu_mem_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORTS(NPORTS)) bus ();

  cpu_mem_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPORTS(NPORTS), .LATENCY(LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then return at the sampling point.
  task automatic applyStimulus(input logic rst, input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1);
    @(posedge clk);
    #1;
    rst_n     = rst;
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
    @(negedge clk);
  endtask

  // Behavioural model: round-robin pointer, memory image and a queue of reads in flight.
  bit                model_on = 1'b0;
  int                m_cyc    = 0;
  int                m_ptr    = 0;
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];
  rd_t               m_rdq   [$];
  logic [DATA_W-1:0] m_rdata  = '0;
  bit                m_rd_ok  = 1'b1;

  always @(negedge clk) begin
    if (model_on) begin
      logic [NPORTS-1:0] exp_gnt;
      logic [NPORTS-1:0] exp_rv;
      int                gp;
      int                idx;
      logic [ADDR_W-1:0] a;
      exp_gnt = '0;
      exp_rv  = '0;
      gp      = -1;
      if (rst_n) begin
        for (int i = 0; i < NPORTS; i++) begin
          idx = (m_ptr + i) % NPORTS;
          if (gp < 0 && bus.req[idx]) gp = idx;
        end
      end
      if (gp >= 0) exp_gnt[gp] = 1'b1;
      checkOutput("gnt", 64'(bus.gnt), 64'(exp_gnt));
      checkOutput("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);

      if (m_rdq.size() > 0 && m_rdq[0].due == m_cyc) begin
        exp_rv[m_rdq[0].port] = 1'b1;
        m_rdata = m_rdq[0].data;
        m_rd_ok = m_rdq[0].known;
        void'(m_rdq.pop_front());
      end
      checkOutput("rvalid", 64'(bus.rvalid), 64'(exp_rv));
      if (m_rd_ok) checkOutput("rdata", 64'(bus.rdata), 64'(m_rdata));

      if (!rst_n) begin
        m_ptr = 0;
        m_rdq.delete();
        m_rdata = '0;
        m_rd_ok = 1'b1;
      end else if (gp >= 0) begin
        m_ptr = (gp + 1) % NPORTS;
        a = bus.addr[gp*ADDR_W +: ADDR_W];
        if (bus.we[gp]) begin
          m_mem[a]   = bus.wdata[gp*DATA_W +: DATA_W];
          m_known[a] = 1'b1;
        end else begin
          m_rdq.push_back('{due: m_cyc + LATENCY, port: gp, data: m_mem[a], known: m_known[a]});
        end
      end
      m_cyc++;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit                pend [NPORTS];
    logic [NPORTS-1:0] p_we;
    logic [ADDR_W-1:0] p_a  [NPORTS];
    logic [DATA_W-1:0] p_d  [NPORTS];
    logic [NPORTS-1:0] g;
    logic [NPORTS-1:0] r;
    logic              rs;

    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    rst_n     = 1'b0;
    bus.req   = 2'b11;
    bus.we    = 2'b11;
    bus.addr  = {8'h01, 8'h00};
    bus.wdata = {16'hA1A1, 16'hA0A0};

    // Two reset edges with both ports requesting.
    @(posedge clk);
    #1;
    model_on = 1'b1;
    @(negedge clk);
    checkOutput("rst_gnt", 64'(bus.gnt), 64'h0);
    checkOutput("rst_rvalid", 64'(bus.rvalid), 64'h0);
    checkOutput("rst_rdata", 64'(bus.rdata), 64'h0);
    applyStimulus(1, 2'b11, 2'b11, 8'h00, 8'h01, 16'hA0A0, 16'hA1A1);
    checkOutput("release_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(1, 2'b10, 2'b11, 8'h00, 8'h01, 16'hA0A0, 16'hA1A1);
    checkOutput("rr_gnt_port1", 64'(bus.gnt), 64'h2);

    // Write then read back the same address with two cycles of latency.
    applyStimulus(1, 2'b01, 2'b01, 8'h10, 8'h01, 16'hBEEF, 16'h0);
    applyStimulus(1, 2'b01, 2'b00, 8'h10, 8'h01, 16'h0, 16'h0);
    checkOutput("wr_rd_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(1, 2'b00, 2'b00, 8'h10, 8'h01, 16'h0, 16'h0);
    checkOutput("wr_rd_rvalid_early", 64'(bus.rvalid), 64'h0);
    applyStimulus(1, 2'b10, 2'b00, 8'h10, 8'h01, 16'h0, 16'h0);
    checkOutput("wr_rd_rvalid", 64'(bus.rvalid), 64'h1);
    checkOutput("wr_rd_rdata", 64'(bus.rdata), 64'hBEEF);

    // Both ports read continuously: grants must alternate starting at port 0.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, (k < 6) ? 2'b11 : 2'b00, 2'b00, 8'h10, 8'h01, 16'h0, 16'h0);
      if (k < 6) checkOutput($sformatf("fair_gnt%0d", k), 64'(bus.gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      checkOutput($sformatf("fair_rvalid%0d", k), 64'(bus.rvalid),
                  (k == 0) ? 64'h0 : ((k % 2 == 1) ? 64'h2 : 64'h1));
      if (k > 0) checkOutput($sformatf("fair_rdata%0d", k), 64'(bus.rdata),
                             (k % 2 == 1) ? 64'hA1A1 : 64'hBEEF);
    end

    // A read in flight is not disturbed by a later write to the same word.
    applyStimulus(1, 2'b01, 2'b01, 8'h20, 8'h20, 16'h1111, 16'h0);
    applyStimulus(1, 2'b10, 2'b00, 8'h20, 8'h20, 16'h0, 16'h0);
    checkOutput("order_rd_gnt", 64'(bus.gnt), 64'h2);
    applyStimulus(1, 2'b01, 2'b01, 8'h20, 8'h20, 16'h2222, 16'h0);
    checkOutput("order_wr_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(1, 2'b01, 2'b00, 8'h20, 8'h20, 16'h0, 16'h0);
    checkOutput("order_old_rvalid", 64'(bus.rvalid), 64'h2);
    checkOutput("order_old_rdata", 64'(bus.rdata), 64'h1111);
    applyStimulus(1, 2'b00, 2'b00, 8'h20, 8'h20, 16'h0, 16'h0);
    checkOutput("order_hold_rdata", 64'(bus.rdata), 64'h1111);
    applyStimulus(1, 2'b00, 2'b00, 8'h20, 8'h20, 16'h0, 16'h0);
    checkOutput("order_new_rvalid", 64'(bus.rvalid), 64'h1);
    checkOutput("order_new_rdata", 64'(bus.rdata), 64'h2222);

    // Reset while a read is in flight: it must vanish, memory must persist.
    applyStimulus(1, 2'b01, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("inflight_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(0, 2'b01, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("midrst_gnt", 64'(bus.gnt), 64'h0);
    applyStimulus(1, 2'b00, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("midrst_rvalid", 64'(bus.rvalid), 64'h0);
    checkOutput("midrst_rdata", 64'(bus.rdata), 64'h0);
    applyStimulus(1, 2'b00, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("midrst_rvalid2", 64'(bus.rvalid), 64'h0);
    applyStimulus(1, 2'b01, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("post_rst_gnt", 64'(bus.gnt), 64'h1);
    applyStimulus(1, 2'b00, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    applyStimulus(1, 2'b00, 2'b00, 8'h10, 8'h10, 16'h0, 16'h0);
    checkOutput("persist_rvalid", 64'(bus.rvalid), 64'h1);
    checkOutput("persist_rdata", 64'(bus.rdata), 64'hBEEF);

    // Random requesters that hold each request until granted, with occasional resets.
    for (int p = 0; p < NPORTS; p++) begin
      pend[p] = 1'b0;
      p_a[p]  = '0;
      p_d[p]  = '0;
    end
    p_we = '0;
    for (int c = 0; c < 1500; c++) begin
      g = bus.gnt;
      for (int p = 0; p < NPORTS; p++) begin
        if (g[p]) pend[p] = 1'b0;
        if (!pend[p] && $urandom_range(99) < 60) begin
          pend[p] = 1'b1;
          p_we[p] = 1'($urandom_range(1));
          p_a[p]  = ADDR_W'($urandom_range(31));
          p_d[p]  = DATA_W'($urandom);
        end
        r[p] = pend[p];
      end
      rs = ($urandom_range(79) != 0);
      applyStimulus(rs, r, p_we, p_a[0], p_a[1], p_d[0], p_d[1]);
    end
    for (int c = 0; c < LATENCY + 3; c++)
      applyStimulus(1, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cpu_mem_arb.md
CPU_MEM_ARB -- requirements
Module: cpu_mem_arb

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter NPORTS, default 2, number of requesters; legal range 1..8.
REQ-004 Parameter LATENCY, default 1, read latency in cycles; legal range 1..4.
REQ-005 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 req  input  NPORTS  per-port access request.
REQ-008 we  input  NPORTS  per-port write enable; 1 = write, 0 = read; qualified by req.
REQ-009 addr  input  NPORTS*ADDR_W  packed per-port word address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 wdata  input  NPORTS*DATA_W  packed per-port write data; same packing rule.
REQ-011 gnt  output  NPORTS  one-hot (or zero) grant, combinational from req and the priority pointer.
REQ-012 rvalid  output  NPORTS  per-port read-data-valid strobe.
REQ-013 rdata  output  DATA_W  shared read data bus.

Function
REQ-014 At most one gnt bit SHALL be high in any cycle; gnt SHALL be zero when req is zero.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer ptr, then ptr+1, and so on, modulo NPORTS; the first requesting port is granted.
REQ-016 On a granting cycle, ptr SHALL become (granted port + 1) mod NPORTS at the next posedge; otherwise ptr SHALL hold.
REQ-017 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the access is accepted in the cycle gnt is high.
REQ-018 Granted write: mem[addr] SHALL take wdata at the posedge ending the grant cycle; no rvalid is generated.
REQ-019 Granted read: rdata SHALL carry mem[addr] and rvalid[p] SHALL be high for exactly one cycle, LATENCY cycles after the grant cycle (LATENCY=1: the cycle after grant).
REQ-020 The read pipeline SHALL accept one new read per cycle; back-to-back reads SHALL produce back-to-back rvalid pulses in grant order.
REQ-021 A read granted in the cycle after a write to the same address SHALL return the newly written data.
REQ-022 The memory array SHALL sample the read value at the grant posedge; a write granted in a later cycle SHALL NOT alter read data already in flight.
REQ-023 rdata SHALL hold its last value while no rvalid is high.
REQ-024 With NPORTS=1, the block SHALL degenerate to gnt = req with ptr fixed at 0.

Reset
REQ-025 While rst_n is low at a posedge: ptr <= 0; all read pipeline stages invalidated; rvalid <= 0; rdata <= 0.
REQ-026 gnt SHALL be forced to zero while rst_n is low.
REQ-027 Memory contents SHALL NOT be cleared by reset and SHALL persist across it.
REQ-028 Reads in flight when reset asserts SHALL be discarded; no rvalid SHALL appear for them after reset release.

Verification
REQ-029 Reset: hold rst_n=0 two cycles with req=2'b11 -> gnt=0, rvalid=0, rdata=0; first cycle after release with req=2'b11 -> gnt=2'b01.
REQ-030 Write/read, LATENCY=2: port 0 writes 16'hBEEF to addr 8'h10, then reads 8'h10 the next cycle -> rvalid[0] high exactly 2 cycles after the read grant, rdata=16'hBEEF.
REQ-031 Fairness: both ports hold continuous read requests for 6 cycles -> grants alternate 01,10,01,10,01,10 and rvalid sequence matches the grant order.
REQ-032 Read/write ordering: port 1 reads 8'h20 (holding 16'h1111), port 0 writes 16'h2222 to 8'h20 the next cycle -> rvalid[1] returns 16'h1111; a subsequent read returns 16'h2222.
REQ-033 Reset mid-operation: grant a read, assert rst_n=0 before its rvalid is due -> no rvalid ever appears for it; memory still holds previously written 16'hBEEF at 8'h10 after release.
REQ-034 Parameter sweep: NPORTS=1,3,4, LATENCY=1,4, DATA_W=32 -> REQ-014..REQ-023 hold, checked by a scoreboard reference model and a one-hot-or-zero assertion on gnt.
